// File: rtl/ram_dump_reader_pkg.sv
// Shared definitions for the RAM dump reader: bus constants and FSM encodings.
package ram_dump_reader_pkg;

  localparam int          BUS_DATA_W     = 32;
  localparam logic [1:0]  DATA_SIZE_WORD = 2'b11;
  localparam int          WORD_BYTES     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_REL,
    ST_PUSH,
    ST_DONE,
    ST_ERR
  } dump_state_e;

  typedef enum logic [1:0] {
    RP_IDLE,
    RP_REQ,
    RP_REL
  } port_state_e;

endpackage

// File: rtl/ram_dump_reader_port.sv
// RAM read handshake: holds cs/oe through REQ, drops them for one REL cycle,
// and reports either the captured word (rd_ok) or a timeout (rd_timeout).
module ram_read_port
  import ram_dump_reader_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  mem_done,
  input  logic [BUS_DATA_W-1:0] rdata_in,
  output logic                  cs,
  output logic                  oe,
  output logic                  rd_ok,
  output logic                  rd_timeout,
  output logic [BUS_DATA_W-1:0] rdata,
  output logic [1:0]            dbg_state
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  port_state_e           state_q, state_d;
  logic [TO_W-1:0]       cnt_q, cnt_d;
  logic [BUS_DATA_W-1:0] rdata_q, rdata_d;
  logic                  cs_q, cs_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    rd_ok      = 1'b0;
    rd_timeout = 1'b0;
    case (state_q)
      RP_IDLE: begin
        if (req) begin
          state_d = RP_REQ;
          cnt_d   = '0;
        end
      end
      RP_REQ: begin
        if (mem_done) begin
          rd_ok   = 1'b1;
          rdata_d = rdata_in;
          state_d = RP_REL;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          rd_timeout = 1'b1;
          state_d    = RP_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RP_REL:  state_d = RP_IDLE;
      default: state_d = RP_IDLE;
    endcase
    // cs/oe come straight from a flop so the RAM never sees an input-driven glitch
    cs_d = (state_d == RP_REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RP_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      cs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      cs_q    <= cs_d;
    end
  end

  assign cs        = cs_q;
  assign oe        = cs_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: rtl/ram_dump_reader.sv
// Reads a contiguous word range out of RAM and streams {addr, word} through a
// valid/ready port while accumulating a 32-bit checksum of accepted words.
module ram_dump_reader
  import ram_dump_reader_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       data_input,
  input  logic [31:0]       data_output,
  input  logic              mem_done,
  output logic              cs,
  output logic              we,
  output logic              oe,
  output logic [1:0]        data_size,
  output logic [31:0]       dout,
  output logic [ADDR_W-1:0] dout_addr,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              finished,
  output logic              error,
  output logic [31:0]       checksum
);

  // Stream handshake: a beat transfers on a rising clk edge where dout_valid
  // and dout_ready are both high; dout/dout_addr hold steady while valid is
  // high, and valid never drops before the transfer.

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] dout_addr_q, dout_addr_d;
  logic [31:0]       sum_q, sum_d;
  logic              dout_valid_q, dout_valid_d;
  logic              busy_q, busy_d;
  logic              finished_q, finished_d;
  logic              error_q, error_d;

  logic              req;
  logic              rd_ok;
  logic              rd_timeout;
  logic [31:0]       rd_data;
  logic [1:0]        port_state_unused;
  logic              unused_base_bits;

  // The port's capture register doubles as the stream data register: it is
  // only reloaded on the next access, which starts after the handshake.
  ram_read_port #(.TIMEOUT(TIMEOUT)) u_port (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .mem_done   (mem_done),
    .rdata_in   (data_output),
    .cs         (cs),
    .oe         (oe),
    .rd_ok      (rd_ok),
    .rd_timeout (rd_timeout),
    .rdata      (rd_data),
    .dbg_state  (port_state_unused)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    dout_addr_d = dout_addr_q;
    sum_d       = sum_q;
    req         = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          ptr_d = {base_addr[ADDR_W-1:2], 2'b00};
          rem_d = word_count;
          sum_d = '0;
          if (word_count == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_REQ;
            req     = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (rd_ok) begin
          dout_addr_d = ptr_q;
          state_d     = ST_REL;
        end else if (rd_timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_REL: state_d = ST_PUSH;
      ST_PUSH: begin
        if (dout_ready) begin
          sum_d = sum_q + rd_data;
          ptr_d = ptr_q + ADDR_W'(WORD_BYTES);
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_REQ;
            req     = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    dout_valid_d = (state_d == ST_PUSH);
    busy_d       = (state_d == ST_REQ) || (state_d == ST_REL) || (state_d == ST_PUSH);
    finished_d   = (state_d == ST_DONE);
    error_d      = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      rem_q        <= '0;
      dout_addr_q  <= '0;
      sum_q        <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rem_q        <= rem_d;
      dout_addr_q  <= dout_addr_d;
      sum_q        <= sum_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      finished_q   <= finished_d;
      error_q      <= error_d;
    end
  end

  // Byte-offset bits of base_addr are deliberately discarded.
  assign unused_base_bits = ^{base_addr[1:0], port_state_unused};

  assign address    = ptr_q;
  assign data_input = '0;
  assign we         = 1'b0;
  assign data_size  = DATA_SIZE_WORD;
  assign dout       = rd_data;
  assign dout_addr  = dout_addr_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign finished   = finished_q;
  assign error      = error_q;
  assign checksum   = sum_q;

endmodule

// File: tb/tb_ram_dump_reader.sv
// Bench for ram_dump_reader: RAM/sink responders, a queue-based model of the
// expected beat stream and checksum, a per-cycle monitor and directed tests.
module tb_ram_dump_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic [31:0] address;
  logic [31:0] data_input;
  logic [31:0] data_output = '0;
  logic        mem_done = 1'b0;
  logic        cs, we, oe;
  logic [1:0]  data_size;
  logic [31:0] dout;
  logic [31:0] dout_addr;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        busy, finished, error;
  logic [31:0] checksum;

  ram_dump_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .address(address), .data_input(data_input),
    .data_output(data_output), .mem_done(mem_done), .cs(cs), .we(we),
    .oe(oe), .data_size(data_size), .dout(dout), .dout_addr(dout_addr),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy),
    .finished(finished), .error(error), .checksum(checksum)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM contents: explicit preload, otherwise an address-derived pattern
  logic [31:0] ram [logic [31:0]];
  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // model state
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] obs_q[$];
  logic [31:0] obs_addr_q[$];
  logic [31:0] exp_sum = '0;

  // responder controls
  bit   force_no_done = 1'b0;
  int   lat_max = 2;
  int   cur_lat = 0;
  int   lat_cnt = 0;
  int   ready_mode = 0;
  int   pat_idx = 0;
  logic [3:0] ready_pat = 4'b1001;
  int   beats_acc = 0;
  int   cs_rise = 0;
  int   cs_hi = 0;
  int   stall_seen = 0;

  // RAM and sink responders, driven 1 time unit after the active edge
  always @(posedge clk) begin
    #1;
    if (cs && !force_no_done && !mem_done) begin
      if (lat_cnt >= cur_lat) begin
        mem_done    = 1'b1;
        data_output = ram_rd(address);
        lat_cnt     = 0;
        cur_lat     = $urandom_range(0, lat_max);
      end else begin
        lat_cnt++;
      end
    end else if (!cs) begin
      // stray strobes while the RAM is not selected must be ignored
      mem_done    = ($urandom_range(0, 7) == 0);
      data_output = $urandom;
      lat_cnt     = 0;
    end else begin
      mem_done = 1'b0;
    end
    case (ready_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = ready_pat[3 - (pat_idx % 4)];
      2:       dout_ready = ($urandom_range(0, 1) == 1);
      default: dout_ready = (beats_acc < 1);
    endcase
    pat_idx++;
  end

  // scoreboard / monitor on the falling edge
  bit          prev_hs = 1'b0;
  bit          prev_stall = 1'b0;
  logic        cs_prev = 1'b0;
  logic [31:0] prev_dout = '0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_hs    = 1'b0;
      prev_stall = 1'b0;
      cs_prev    = 1'b0;
    end else begin
      logic [31:0] ed, ea;
      bit hs;
      check32("checksum_track", checksum, exp_sum);
      check32("bus_ctrl", {26'd0, we, cs ^ oe, dout_valid & cs, data_size, |data_input}, 32'd6);
      if (cs && !cs_prev) cs_rise++;
      if (cs) cs_hi++;
      if (prev_hs) check32("valid_drop", 32'(dout_valid), 32'd0);
      if (prev_stall) begin
        stall_seen++;
        check32("stall_valid", 32'(dout_valid), 32'd1);
        check32("stall_dout", dout, prev_dout);
        check32("stall_addr", dout_addr, prev_addr);
      end
      hs = dout_valid && dout_ready;
      if (hs) begin
        check32("beat_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          ed = exp_q.pop_front();
          ea = exp_addr_q.pop_front();
          check32("beat_data", dout, ed);
          check32("beat_addr", dout_addr, ea);
          exp_sum = exp_sum + ed;
        end
        obs_q.push_back(dout);
        obs_addr_q.push_back(dout_addr);
        beats_acc++;
      end
      prev_hs    = hs;
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
      prev_addr  = dout_addr;
      cs_prev    = cs;
    end
  end

  // driver tasks
  task automatic do_start(input logic [31:0] b, input int n);
    logic [31:0] a;
    @(posedge clk); #1;
    start      = 1'b1;
    base_addr  = b;
    word_count = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
    exp_sum = '0;
    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < n; i++) begin
      a = {b[31:2], 2'b00} + 32'(4 * i);
      exp_addr_q.push_back(a);
      exp_q.push_back(ram_rd(a));
    end
    @(negedge clk);
    check32("start_flags", {29'd0, busy, finished, error}, (n == 0) ? 32'd2 : 32'd4);
  endtask

  task automatic wait_end(input int budget, input bit spur);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (finished || error) begin
        done = 1'b1;
        break;
      end
      if (spur && i == 3) begin
        @(posedge clk); #1;
        if (busy) begin
          start      = 1'b1;
          base_addr  = $urandom;
          word_count = 16'($urandom_range(1, 5));
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    end
    check32("end_reached", 32'(done), 32'd1);
  endtask

  task automatic check_end();
    check32("queue_empty", 32'(exp_q.size()), 32'd0);
    check32("end_checksum", checksum, exp_sum);
    check32("end_flags", {29'd0, busy, finished, error}, 32'd2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_address"}, address, 32'd0);
    check32({tag, "_ctrl"}, {25'd0, cs, oe, we, dout_valid, busy, finished, error}, 32'd0);
    check32({tag, "_dout"}, dout, 32'd0);
    check32({tag, "_dout_addr"}, dout_addr, 32'd0);
    check32({tag, "_checksum"}, checksum, 32'd0);
    check32({tag, "_size_data"}, {data_input[29:0], data_size}, 32'd3);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_addr_q.delete();
    cs_rise = 0;
    cs_hi = 0;
    stall_seen = 0;
    beats_acc = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ram[32'h100] = 32'h1111_1111;
    ram[32'h104] = 32'h2222_2222;
    ram[32'h108] = 32'h3333_3333;
    ram[32'h10C] = 32'h4444_4444;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst0");
    @(posedge clk); #1;
    rst = 1'b1;

    // four words, sink always ready
    ready_mode = 0;
    clear_obs();
    do_start(32'h100, 4);
    wait_end(500, 1'b0);
    check_end();
    check32("t1_checksum", checksum, 32'hAAAA_AAAA);
    check32("t1_cs_pulses", 32'(cs_rise), 32'd4);
    check32("t1_beats", 32'(obs_q.size()), 32'd4);
    if (obs_q.size() == 4) begin
      check32("t1_addr0", obs_addr_q[0], 32'h100);
      check32("t1_addr3", obs_addr_q[3], 32'h10C);
      check32("t1_data2", obs_q[2], 32'h3333_3333);
    end

    // same range, ready pattern 1-0-0-1
    ready_mode = 1;
    pat_idx = 0;
    clear_obs();
    do_start(32'h100, 4);
    wait_end(500, 1'b0);
    check_end();
    check32("t2_checksum", checksum, 32'hAAAA_AAAA);
    check32("t2_stalled", 32'(stall_seen > 0), 32'd1);

    // zero-length dump
    ready_mode = 0;
    clear_obs();
    do_start(32'h40, 0);
    wait_end(20, 1'b0);
    check_end();
    check32("t3_no_cs", 32'(cs_rise), 32'd0);
    check32("t3_checksum", checksum, 32'd0);

    // unaligned base
    clear_obs();
    do_start(32'h103, 1);
    wait_end(100, 1'b0);
    check_end();
    check32("t4_beats", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() == 1) begin
      check32("t4_addr", obs_addr_q[0], 32'h100);
      check32("t4_data", obs_q[0], 32'h1111_1111);
    end

    // RAM never answers
    force_no_done = 1'b1;
    clear_obs();
    do_start(32'h200, 2);
    wait_end(300, 1'b0);
    check32("t5_error", 32'(error), 32'd1);
    check32("t5_req_cycles", 32'(cs_hi), 32'd64);
    check32("t5_idle_ctrl", {28'd0, cs, busy, finished, dout_valid}, 32'd0);
    check32("t5_checksum", checksum, 32'd0);
    force_no_done = 1'b0;
    do_start(32'h100, 1);
    wait_end(100, 1'b0);
    check_end();
    check32("t5_recover_sum", checksum, 32'h1111_1111);

    // randomized dumps, including an address wrap and ignored starts while busy
    for (int k = 0; k < 10; k++) begin
      logic [31:0] b;
      int n;
      b = (k == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 3))) : $urandom;
      n = (k == 0) ? 4 : $urandom_range(0, 6);
      ready_mode = 2;
      lat_max = $urandom_range(0, 3);
      clear_obs();
      do_start(b, n);
      wait_end(3000, k[0]);
      check_end();
      if (k == 0 && obs_addr_q.size() == 4) check32("wrap_addr2", obs_addr_q[2], 32'h0);
    end

    // reset while stalled in PUSH on the second beat
    ready_mode = 3;
    lat_max = 1;
    clear_obs();
    do_start(32'h100, 4);
    begin
      bit found = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (dout_valid && beats_acc == 1) begin
          found = 1'b1;
          break;
        end
      end
      check32("t7_reached_push2", 32'(found), 32'd1);
    end
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    exp_q.delete();
    exp_addr_q.delete();
    exp_sum = '0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    ready_mode = 0;
    clear_obs();
    do_start(32'h100, 4);
    wait_end(500, 1'b0);
    check_end();
    check32("t7_checksum", checksum, 32'hAAAA_AAAA);
    check32("t7_cs_pulses", 32'(cs_rise), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
